hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. It sits beside the D stage and tracks the destination register and remaining result latency (Tnew) of instructions in E, M and W. For each register-file read port in D it produces a stall or a forward select, so that the combinational reads of the general register file, which have no internal write-to-read bypass, always receive current data. It also owns the multiply/divide busy counter and stalls HI/LO users while that counter is non-zero.

---
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage MIPS core: tracks E/M/W destination tags and
// result latency, and produces D-stage stall and forward selects plus the md busy counter.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       D_Valid,
    input  logic [4:0] D_A1,
    input  logic [4:0] D_A2,
    input  logic [1:0] D_Tuse1,
    input  logic [1:0] D_Tuse2,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tnew,
    input  logic       D_IsMd,
    input  logic       D_MdStart,
    input  logic       D_MdDiv,
    output logic       Stall,
    output logic [1:0] Fwd1,
    output logic [1:0] Fwd2,
    output logic       MdBusy
);

    localparam int unsigned REG_W = 5;
    localparam int unsigned T_W   = 2;
    localparam int unsigned MD_W  = 4;
    localparam int unsigned FWD_W = 2;

    localparam logic [T_W-1:0]   TUSE_NONE = T_W'(3);
    localparam logic [FWD_W-1:0] FWD_GRF   = FWD_W'(0);
    localparam logic [FWD_W-1:0] FWD_E     = FWD_W'(1);
    localparam logic [FWD_W-1:0] FWD_M     = FWD_W'(2);
    localparam logic [FWD_W-1:0] FWD_W_SEL = FWD_W'(3);

    logic [REG_W-1:0] e_a3_q, e_a3_d;
    logic [T_W-1:0]   e_tnew_q, e_tnew_d;
    logic [REG_W-1:0] m_a3_q, m_a3_d;
    logic [T_W-1:0]   m_tnew_q, m_tnew_d;
    logic [REG_W-1:0] w_a3_q, w_a3_d;
    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;

    logic             stall1_c, stall2_c, stall_c, md_busy_c;
    logic [FWD_W-1:0] fwd1_c, fwd2_c;

    // Nearest-stage tag search for one read port: returns {stall, fwd_sel}.
    // A3 = 0 can never match because a zero source index is filtered first.
    function automatic logic [FWD_W:0] src_eval(
        input logic [REG_W-1:0] a,
        input logic [T_W-1:0]   tuse,
        input logic [REG_W-1:0] ea3,
        input logic [T_W-1:0]   etnew,
        input logic [REG_W-1:0] ma3,
        input logic [T_W-1:0]   mtnew,
        input logic [REG_W-1:0] wa3
    );
        logic             stl;
        logic [FWD_W-1:0] sel;
        stl = 1'b0;
        sel = FWD_GRF;
        if ((a != '0) && (tuse != TUSE_NONE)) begin
            if (ea3 == a) begin
                stl = (etnew > tuse);
                sel = (etnew == '0) ? FWD_E : FWD_GRF;
            end else if (ma3 == a) begin
                stl = (mtnew > tuse);
                sel = (mtnew == '0) ? FWD_M : FWD_GRF;
            end else if (wa3 == a) begin
                sel = FWD_W_SEL;
            end
        end
        return {stl, sel};
    endfunction

    // Hazard decisions and next tag / counter state.
    always_comb begin
        stall1_c  = 1'b0;
        stall2_c  = 1'b0;
        fwd1_c    = FWD_GRF;
        fwd2_c    = FWD_GRF;
        md_busy_c = (md_cnt_q != '0);
        e_a3_d    = '0;
        e_tnew_d  = '0;
        m_a3_d    = e_a3_q;
        m_tnew_d  = (e_tnew_q == '0) ? '0 : e_tnew_q - T_W'(1);
        w_a3_d    = m_a3_q;
        md_cnt_d  = md_cnt_q;

        {stall1_c, fwd1_c} = src_eval(D_A1, D_Tuse1, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);
        {stall2_c, fwd2_c} = src_eval(D_A2, D_Tuse2, e_a3_q, e_tnew_q, m_a3_q, m_tnew_q, w_a3_q);

        stall_c = D_Valid & (stall1_c | stall2_c | (D_IsMd & md_busy_c));

        if (D_Valid && !stall_c) begin
            e_a3_d   = D_A3;
            e_tnew_d = D_Tnew;
        end

        // Load on the edge the start enters E so the next D instruction sees busy at once.
        if (D_Valid && D_MdStart && !stall_c) begin
            md_cnt_d = D_MdDiv ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            e_a3_q   <= '0;
            e_tnew_q <= '0;
            m_a3_q   <= '0;
            m_tnew_q <= '0;
            w_a3_q   <= '0;
            md_cnt_q <= '0;
        end else begin
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            w_a3_q   <= w_a3_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign Stall  = stall_c;
    assign Fwd1   = fwd1_c;
    assign Fwd2   = fwd2_c;
    assign MdBusy = md_busy_c;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a cycle-indexed
// model that remembers when each accepted instruction's result becomes available.
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int HIST   = 4096;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       D_Valid;
    logic [4:0] D_A1, D_A2, D_A3;
    logic [1:0] D_Tuse1, D_Tuse2, D_Tnew;
    logic       D_IsMd, D_MdStart, D_MdDiv;
    logic       Stall, MdBusy;
    logic [1:0] Fwd1, Fwd2;

    hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .Clk(Clk), .Reset(Reset), .D_Valid(D_Valid),
        .D_A1(D_A1), .D_A2(D_A2), .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2),
        .D_A3(D_A3), .D_Tnew(D_Tnew), .D_IsMd(D_IsMd), .D_MdStart(D_MdStart),
        .D_MdDiv(D_MdDiv), .Stall(Stall), .Fwd1(Fwd1), .Fwd2(Fwd2), .MdBusy(MdBusy)
    );

    always #5 Clk = ~Clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: instruction accepted at the end of cycle c sits in E during c+1,
    // M during c+2, W during c+3; its result exists from cycle c+1+Tnew on.
    bit         acc [HIST];
    logic [4:0] h_a3 [HIST];
    int         h_ready [HIST];
    int         cyc = 0;
    int         base = 0;
    int         md_until = 0;

    logic       obs_stall, obs_busy;
    logic [1:0] obs_f1, obs_f2;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_src(input logic [4:0] a, input logic [1:0] tuse,
                             output logic s, output logic [1:0] f);
        s = 1'b0;
        f = 2'd0;
        if (a != 5'd0 && tuse != 2'd3) begin
            for (int k = 1; k <= 3; k++) begin
                int c0;
                c0 = cyc - k;
                if (c0 >= base && acc[c0] && h_a3[c0] == a) begin
                    int rem;
                    rem = h_ready[c0] - cyc;
                    if (rem < 0) rem = 0;
                    if (k <= 2 && rem > int'(tuse)) s = 1'b1;
                    f = (rem == 0) ? 2'(k) : 2'd0;
                    break;
                end
            end
        end
    endtask

    // One D-stage cycle: drive, sample at negedge against the model, advance at posedge.
    task automatic step(input logic v, input logic [4:0] a1, input logic [1:0] t1,
                        input logic [4:0] a2, input logic [1:0] t2,
                        input logic [4:0] a3, input logic [1:0] tn,
                        input logic ismd, input logic mds, input logic mdd);
        logic s1, s2, es, mb;
        logic [1:0] f1, f2;
        D_Valid = v; D_A1 = a1; D_Tuse1 = t1; D_A2 = a2; D_Tuse2 = t2;
        D_A3 = a3; D_Tnew = tn; D_IsMd = ismd; D_MdStart = mds; D_MdDiv = mdd;
        @(negedge Clk);
        model_src(a1, t1, s1, f1);
        model_src(a2, t2, s2, f2);
        mb = (cyc < md_until);
        es = v & (s1 | s2 | (ismd & mb));
        obs_stall = Stall; obs_f1 = Fwd1; obs_f2 = Fwd2; obs_busy = MdBusy;
        check("model_stall", 4'(Stall), 4'(es));
        check("model_busy", 4'(MdBusy), 4'(mb));
        if (!es) begin
            check("model_fwd1", 4'(Fwd1), 4'(f1));
            check("model_fwd2", 4'(Fwd2), 4'(f2));
        end
        @(posedge Clk);
        acc[cyc] = v & ~es;
        h_a3[cyc] = a3;
        h_ready[cyc] = cyc + 1 + int'(tn);
        if (v && !es && mds) md_until = cyc + 1 + (mdd ? DIV_N : MULT_N);
        cyc++;
        #1;
    endtask

    task automatic nop();
        step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        Reset = 1'b1;
        D_Valid = 1'b0; D_A1 = '0; D_A2 = '0; D_A3 = '0; D_Tuse1 = 2'd3; D_Tuse2 = 2'd3;
        D_Tnew = '0; D_IsMd = 1'b0; D_MdStart = 1'b0; D_MdDiv = 1'b0;
        #1;
        check("rst_stall", 4'(Stall), 4'd0);
        check("rst_fwd1", 4'(Fwd1), 4'd0);
        check("rst_fwd2", 4'(Fwd2), 4'd0);
        check("rst_busy", 4'(MdBusy), 4'd0);
        @(negedge Clk); Reset = 1'b0;
        @(posedge Clk); #1;

        // lw $3 then a user of $3 with Tuse=1
        step(1, 0, 3, 0, 3, 3, 2, 0, 0, 0);
        step(1, 3, 1, 0, 3, 8, 1, 0, 0, 0);
        check("lw_stall", 4'(obs_stall), 4'd1);
        step(1, 3, 1, 0, 3, 8, 1, 0, 0, 0);
        check("lw_release", 4'(obs_stall), 4'd0);
        check("lw_fwd_none", 4'(obs_f1), 4'd0);
        step(1, 3, 1, 0, 3, 0, 0, 0, 0, 0);
        check("lw_fwd_w", 4'(obs_f1), 4'd3);
        nop(); nop(); nop();

        // ALU result feeding a branch compare
        step(1, 0, 3, 0, 3, 5, 1, 0, 0, 0);
        step(1, 5, 0, 0, 3, 0, 0, 0, 0, 0);
        check("beq_stall", 4'(obs_stall), 4'd1);
        step(1, 5, 0, 0, 3, 0, 0, 0, 0, 0);
        check("beq_release", 4'(obs_stall), 4'd0);
        check("beq_fwd_m", 4'(obs_f1), 4'd2);
        nop(); nop(); nop();

        // Nearest stage wins when E and W both write $7
        step(1, 0, 3, 0, 3, 7, 0, 0, 0, 0);
        step(1, 0, 3, 0, 3, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 3, 7, 0, 0, 0, 0);
        step(1, 7, 1, 7, 1, 0, 0, 0, 0, 0);
        check("prio_stall", 4'(obs_stall), 4'd0);
        check("prio_fwd1", 4'(obs_f1), 4'd1);
        check("prio_fwd2", 4'(obs_f2), 4'd1);
        nop(); nop(); nop();

        // $0 never matches; Tuse=3 is not a read
        step(1, 0, 3, 0, 3, 0, 2, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("r0_stall", 4'(obs_stall), 4'd0);
        check("r0_fwd1", 4'(obs_f1), 4'd0);
        step(1, 0, 3, 0, 3, 4, 2, 0, 0, 0);
        step(1, 9, 0, 4, 3, 0, 0, 0, 0, 0);
        check("unused_stall", 4'(obs_stall), 4'd0);
        check("unused_fwd2", 4'(obs_f2), 4'd0);
        nop(); nop(); nop();

        // div then mflo: DIV_N stall cycles
        step(1, 0, 3, 0, 3, 0, 0, 1, 1, 1);
        for (int i = 0; i < DIV_N; i++) begin
            step(1, 0, 3, 0, 3, 2, 0, 1, 0, 0);
            check("div_stall", 4'(obs_stall), 4'd1);
            check("div_busy", 4'(obs_busy), 4'd1);
        end
        step(1, 0, 3, 0, 3, 2, 0, 1, 0, 0);
        check("div_release", 4'(obs_stall), 4'd0);
        check("div_idle", 4'(obs_busy), 4'd0);

        // mult then mfhi: MULT_N stall cycles
        step(1, 0, 3, 0, 3, 0, 0, 1, 1, 0);
        check("mult_accept", 4'(obs_stall), 4'd0);
        for (int i = 0; i < MULT_N; i++) begin
            step(1, 0, 3, 0, 3, 2, 0, 1, 0, 0);
            check("mult_stall", 4'(obs_stall), 4'd1);
        end
        step(1, 0, 3, 0, 3, 2, 0, 1, 0, 0);
        check("mult_release", 4'(obs_stall), 4'd0);
        nop(); nop(); nop();

        // Reset in the middle of a stall with the md counter running
        step(1, 0, 3, 0, 3, 0, 0, 1, 1, 1);
        step(1, 0, 3, 0, 3, 3, 2, 0, 0, 0);
        step(1, 3, 0, 0, 3, 8, 1, 0, 0, 0);
        check("pre_rst_stall", 4'(obs_stall), 4'd1);
        check("pre_rst_busy", 4'(obs_busy), 4'd1);
        #3;
        Reset = 1'b1;
        #1;
        check("mid_rst_stall", 4'(Stall), 4'd0);
        check("mid_rst_fwd1", 4'(Fwd1), 4'd0);
        check("mid_rst_busy", 4'(MdBusy), 4'd0);
        D_Valid = 1'b0;
        @(negedge Clk); Reset = 1'b0;
        @(posedge Clk);
        cyc++;
        base = cyc;
        md_until = 0;
        #1;
        step(1, 3, 0, 0, 3, 0, 0, 0, 0, 0);
        check("post_rst_stall", 4'(obs_stall), 4'd0);

        // Random traffic over a small register set to provoke frequent matches
        for (int i = 0; i < 600; i++) begin
            logic ismd, mds;
            ismd = ($urandom_range(0, 5) == 0);
            mds  = ismd & $urandom_range(0, 1) == 1;
            step($urandom_range(0, 7) != 0,
                 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 5'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
                 ismd, mds, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
